dense1_stream_tx: RTL and testbench
===================================

Name: dense1_stream_tx

Overview:
- Transmit side of the dense1 input frame protocol.
- Accepts one flattened feature frame from the upstream pool/flatten stage through a random-access write port and buffers it.
- On commit, serializes the frame as signed 16-bit words, marking the first word with frame_start and the last with frame_end.
- The tx_valid output drives dense1's ena input.

Parameters:
- DATA_W, 16, word width (signed).
- FRAME_LEN, 980, words per frame.
- ADDR_W, $clog2(FRAME_LEN), buffer address width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  signed word to store.
- wr_commit  input  1  frame fully loaded; start streaming.
- wr_ready  output  1  buffer accepts writes/commit.
- wr_err  output  1  sticky illegal-write flag.
- tx_stall  input  1  downstream hold; no word issued this cycle.
- tx_valid  output  1  dense_input carries a new word (drives dense1 ena).
- frame_start_out  output  1  with word 0 only.
- frame_end_out  output  1  with word FRAME_LEN-1 only.
- dense_input  output  DATA_W  signed word.
- frame_done  output  1  one-cycle pulse after the last word.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=LOAD, idx=0.
  - tx_valid, frame_start_out, frame_end_out, frame_done, wr_err = 0.
  - dense_input = 0.
  - wr_ready = 1 from the cycle after reset.
  - Buffer contents are not cleared.
  - Applies mid-stream: the stream aborts with no frame_end and no frame_done.
- States: LOAD, STREAM, DONE.
- LOAD:
  - wr_ready=1.
  - wr_en with wr_addr<FRAME_LEN writes the buffer at the edge.
  - wr_commit moves to STREAM with idx=0.
  - wr_en and wr_commit in the same cycle: the write lands and is part of the frame.
- STREAM:
  - wr_ready=0.
  - Each edge with tx_stall=0: dense_input<=buf[idx], tx_valid<=1, frame_start_out<=(idx==0), frame_end_out<=(idx==FRAME_LEN-1), idx++.
  - Each edge with tx_stall=1: tx_valid and both strobes <=0, dense_input holds, idx holds.
  - After issuing idx==FRAME_LEN-1, go to DONE.
  - Read is a synchronous RAM read with read-enable = !tx_stall.
  - Latency: commit sampled at edge C gives word 0 registered at edge C+1 (if unstalled). A zero-stall frame occupies exactly FRAME_LEN consecutive tx_valid cycles.
- DONE (one cycle):
  - tx_valid and strobes = 0, frame_done=1.
  - Next state LOAD; wr_ready returns to 1 the cycle after frame_done.
- FRAME_LEN==1: frame_start_out and frame_end_out assert together on the single word.
- Illegal writes set wr_err (cleared only by rst) and are otherwise ignored:
  - wr_en while wr_ready=0;
  - wr_addr>=FRAME_LEN.
- wr_commit while not in LOAD is ignored and does not set wr_err.
- tx_stall is ignored outside STREAM.

Optional Feature:
- Macro: DENSE1_TX_CHECKSUM_EN.
- Defined:
  - Adds output frame_checksum [DATA_W-1:0].
  - Holds the modulo-2^DATA_W sum of every word issued in the frame.
  - Valid in the frame_done cycle and held until the next frame's first issue.
  - Reset value 0; the accumulator clears when entering STREAM.
- Undefined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package dense1_tx_pkg:
  - DATA_W and FRAME_LEN defaults;
  - typedef dense_word_t (logic signed [DATA_W-1:0]);
  - state enum tx_state_e {LOAD, STREAM, DONE}.
- Sub-module dense1_tx_buf: simple dual-port RAM, one sync write port, one sync read port with read-enable, no reset on storage.
- FSM, index counter and output registers stay in dense1_stream_tx.

Test Plan:
- Basic frame (FRAME_LEN=4):
  - Stimulus: write 10,-3,7,32767 to addrs 0..3, commit, tx_stall=0.
  - Response: 4 consecutive tx_valid words 10,-3,7,32767; frame_start_out on word 10; frame_end_out on word 32767; frame_done the next cycle; wr_ready=1 one cycle later.
- Stall:
  - Stimulus: same frame, tx_stall=1 on the 2nd and 3rd STREAM cycles.
  - Response: tx_valid gaps of 2 cycles; order unchanged; dense_input holds 10 during the gap; 6 cycles from first to last word.
- Illegal writes:
  - Stimulus: wr_en during STREAM, and wr_addr=4 during LOAD.
  - Response: buffer unchanged, wr_err=1; a second frame streams the original data.
- Same-cycle write+commit:
  - Stimulus: wr_en addr3 data -1 together with wr_commit.
  - Response: word 3 = -1.
- Reset mid-stream:
  - Stimulus: rst after word 1.
  - Response: next cycle all outputs 0, no frame_end/frame_done, wr_ready=1; a fresh commit restarts at word 0.
- Checksum (DENSE1_TX_CHECKSUM_EN):
  - Stimulus: words 32767,1,0,0.
  - Response: frame_checksum=16'h8000 during frame_done.

Source files
------------

// File: rtl/dense1_tx_pkg.sv
// dense1_tx_pkg: shared defaults and types for the dense1 input-frame transmitter.
//   DENSE1_DATA_W    default word width (signed words)
//   DENSE1_FRAME_LEN default words per frame
//   dense_word_t     one signed frame word
//   tx_state_e       transmitter FSM states
package dense1_tx_pkg;

  localparam int unsigned DENSE1_DATA_W    = 16;
  localparam int unsigned DENSE1_FRAME_LEN = 980;

  typedef logic signed [DENSE1_DATA_W-1:0] dense_word_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/dense1_tx_buf.sv
// dense1_tx_buf: simple dual-port frame buffer.
//   clk         clock, rising edge
//   rst         sync active-high reset, clears the read register only
//   we/waddr/wdata  synchronous write port
//   re/raddr    synchronous read port; rdata updates only when re=1, else holds
//   rdata       registered read data
// Storage is never reset; depth is the full 2**ADDR_W address space.
module dense1_tx_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port with enable; the held value doubles as the stalled output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dense1_stream_tx.sv
// dense1_stream_tx: buffers one flattened feature frame and streams it to dense1.
//   clk, rst          clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data  random-access frame write port
//   wr_commit         frame loaded, start streaming
//   wr_ready          writes/commit accepted
//   wr_err            sticky illegal-write flag (cleared by rst only)
//   tx_stall          downstream hold, no word issued this cycle
//   tx_valid          dense_input carries a new word (dense1 ena)
//   frame_start_out   with word 0; frame_end_out with the last word
//   dense_input       signed output word
//   frame_done        one-cycle pulse after the last word
//   frame_checksum    (DENSE1_TX_CHECKSUM_EN only) mod-2^DATA_W sum of the frame
// Optional feature macro: DENSE1_TX_CHECKSUM_EN.
module dense1_stream_tx
  import dense1_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = DENSE1_DATA_W,
  parameter int unsigned FRAME_LEN = DENSE1_FRAME_LEN,
  parameter int unsigned ADDR_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     wr_commit,
  output logic                     wr_ready,
  output logic                     wr_err,
  input  logic                     tx_stall,
  output logic                     tx_valid,
  output logic                     frame_start_out,
  output logic                     frame_end_out,
  output logic signed [DATA_W-1:0] dense_input,
  output logic                     frame_done
`ifdef DENSE1_TX_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]        frame_checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              tx_valid_d, start_d, end_d, done_d, ready_d, err_d;
  logic              ram_we, ram_re;
  logic              wr_in_range;

  assign wr_in_range = 32'(wr_addr) < FRAME_LEN;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_valid_d = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    done_d     = 1'b0;
    ready_d    = wr_ready;
    err_d      = wr_err;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    if (wr_en && !(wr_ready && wr_in_range)) begin
      err_d = 1'b1;
    end

    case (state_q)
      LOAD: begin
        // wr_ready is still low in the frame_done cycle; nothing is accepted then.
        ready_d = 1'b1;
        if (wr_ready) begin
          ram_we = wr_en && wr_in_range;
          if (wr_commit) begin
            state_d = STREAM;
            idx_d   = '0;
            ready_d = 1'b0;
          end
        end
      end
      STREAM: begin
        ready_d = 1'b0;
        if (!tx_stall) begin
          ram_re     = 1'b1;
          tx_valid_d = 1'b1;
          start_d    = (idx_q == '0);
          end_d      = (idx_q == LAST_IDX);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        ready_d = 1'b0;
        idx_d   = '0;
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= LOAD;
      idx_q           <= '0;
      tx_valid        <= 1'b0;
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      frame_done      <= 1'b0;
      wr_ready        <= 1'b1;
      wr_err          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      tx_valid        <= tx_valid_d;
      frame_start_out <= start_d;
      frame_end_out   <= end_d;
      frame_done      <= done_d;
      wr_ready        <= ready_d;
      wr_err          <= err_d;
    end
  end

  // The buffer's read register is dense_input itself, giving one-cycle issue latency.
  dense1_tx_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (idx_q),
    .rdata (dense_input)
  );

`ifdef DENSE1_TX_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d, csum_d;

  // Words are summed the cycle they are visible; the last one lands during DONE.
  always_comb begin
    acc_d  = acc_q;
    csum_d = frame_checksum;
    if (state_q == LOAD && wr_ready && wr_commit) begin
      acc_d = '0;
    end else if (tx_valid) begin
      acc_d = acc_q + DATA_W'(dense_input);
    end
    if (state_q == DONE) begin
      csum_d = acc_q + (tx_valid ? DATA_W'(dense_input) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q          <= '0;
      frame_checksum <= '0;
    end else begin
      acc_q          <= acc_d;
      frame_checksum <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_dense1_stream_tx.sv
// tb_dense1_stream_tx: directed plus randomized checks of dense1_stream_tx (FRAME_LEN=4).
module tb_dense1_stream_tx;
  import dense1_tx_pkg::*;

  localparam int unsigned FL = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_en = 1'b0;
  logic [AW-1:0]        wr_addr = '0;
  logic signed [DW-1:0] wr_data = '0;
  logic                 wr_commit = 1'b0;
  logic                 tx_stall = 1'b0;
  logic                 wr_ready, wr_err, tx_valid, frame_start_out, frame_end_out, frame_done;
  logic signed [DW-1:0] dense_input;
`ifdef DENSE1_TX_CHECKSUM_EN
  logic [DW-1:0]        frame_checksum;
`endif

  int errors = 0;
  int checks = 0;
  dense_word_t model_mem [FL];

  always #5 clk = ~clk;

  dense1_stream_tx #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .ADDR_W    (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_commit       (wr_commit),
    .wr_ready        (wr_ready),
    .wr_err          (wr_err),
    .tx_stall        (tx_stall),
    .tx_valid        (tx_valid),
    .frame_start_out (frame_start_out),
    .frame_end_out   (frame_end_out),
    .dense_input     (dense_input),
    .frame_done      (frame_done)
`ifdef DENSE1_TX_CHECKSUM_EN
    ,
    .frame_checksum  (frame_checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the call are sampled at the rising edge,
  // outputs are observed at the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_write(input int addr, input dense_word_t data, input bit legal);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    step();
    wr_en = 1'b0;
    if (legal) model_mem[addr] = data;
  endtask

  task automatic do_commit();
    wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
  endtask

  // Called right after the commit edge. Words must appear on the first FL
  // unstalled edges; extra=1 injects a write mid-stream, extra=2 a stray commit.
  task automatic run_frame(input logic [31:0] mask, input string tag, input int extra);
    int pos[$];
    int n;
    int last;
    bit is_issue;
    logic [DW-1:0] csum;
    pos = {};
    for (int i = 0; i < 32 && pos.size() < FL; i++) if (!mask[i]) pos.push_back(i);
    last = pos[FL-1];
    n = 0;
    csum = '0;
    for (int cyc = 0; cyc <= last + 2; cyc++) begin
      tx_stall = mask[cyc];
      if (cyc == 1 && extra == 1) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 16'sh1234;
      end
      if (cyc == 1 && extra == 2) wr_commit = 1'b1;
      step();
      wr_en = 1'b0;
      wr_commit = 1'b0;
      if (cyc <= last) begin
        is_issue = (n < FL) && (cyc == pos[n]);
        check({tag, " tx_valid"}, tx_valid, is_issue);
        if (is_issue) begin
          check({tag, " data"}, dense_input, model_mem[n]);
          check({tag, " start"}, frame_start_out, (n == 0));
          check({tag, " end"}, frame_end_out, (n == FL - 1));
          csum = csum + DW'(model_mem[n]);
          n++;
        end else begin
          check({tag, " strobes idle"}, {frame_start_out, frame_end_out}, 2'b00);
          if (n > 0) check({tag, " hold"}, dense_input, model_mem[n-1]);
        end
        check({tag, " ready stream"}, wr_ready, 1'b0);
        check({tag, " done early"}, frame_done, 1'b0);
      end else if (cyc == last + 1) begin
        check({tag, " frame_done"}, frame_done, 1'b1);
        check({tag, " valid after"}, tx_valid, 1'b0);
        check({tag, " ready in done"}, wr_ready, 1'b0);
`ifdef DENSE1_TX_CHECKSUM_EN
        check({tag, " checksum"}, frame_checksum, csum);
`endif
      end else begin
        check({tag, " done pulse"}, frame_done, 1'b0);
        check({tag, " ready back"}, wr_ready, 1'b1);
      end
    end
    check({tag, " word count"}, n, FL);
    tx_stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mask;

    // Reset state.
    step(); step();
    rst = 1'b0;
    check("rst tx_valid", tx_valid, 1'b0);
    check("rst strobes", {frame_start_out, frame_end_out, frame_done}, 3'b000);
    check("rst wr_err", wr_err, 1'b0);
    check("rst dense_input", dense_input, 16'h0000);
    check("rst wr_ready", wr_ready, 1'b1);

    // Basic frame.
    do_write(0, 16'sd10, 1'b1);
    do_write(1, -16'sd3, 1'b1);
    do_write(2, 16'sd7, 1'b1);
    do_write(3, 16'sd32767, 1'b1);
    do_commit();
    run_frame(32'h0, "basic", 0);
    check("basic wr_err", wr_err, 1'b0);

    // Stalls on the 2nd and 3rd stream edges, plus an ignored commit mid-stream.
    do_commit();
    run_frame(32'h6, "stall", 2);
    check("stray commit no err", wr_err, 1'b0);

    // Write during STREAM is rejected and flagged; data is preserved.
    do_commit();
    run_frame(32'h0, "wr_in_stream", 1);
    check("stream write err", wr_err, 1'b1);
    do_commit();
    run_frame(32'h0, "after stream write", 0);

    // Reset clears wr_err; out-of-range address is rejected and flagged.
    rst = 1'b1; step(); rst = 1'b0;
    check("err cleared by rst", wr_err, 1'b0);
    do_write(4, 16'sd99, 1'b0);
    check("range write err", wr_err, 1'b1);
    do_commit();
    run_frame(32'h0, "after range write", 0);

    // Write and commit in the same cycle.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = -16'sd1; model_mem[3] = -16'sd1;
    do_commit();
    wr_en = 1'b0;
    run_frame(32'h0, "write+commit", 0);

    // Reset mid-stream after word 1.
    do_commit();
    tx_stall = 1'b0;
    step();
    check("mid word0", dense_input, model_mem[0]);
    step();
    check("mid word1", dense_input, model_mem[1]);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid rst outputs", {tx_valid, frame_start_out, frame_end_out, frame_done}, 4'b0000);
    check("mid rst data", dense_input, 16'h0000);
    check("mid rst ready", wr_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid rst quiet", {tx_valid, frame_end_out, frame_done}, 3'b000);
    end
    do_commit();
    run_frame(32'h0, "restart", 0);

    // Checksum wrap frame.
    do_write(0, 16'sd32767, 1'b1);
    do_write(1, 16'sd1, 1'b1);
    do_write(2, 16'sd0, 1'b1);
    do_write(3, 16'sd0, 1'b1);
    do_commit();
    run_frame(32'h0, "checksum", 0);

    // Randomized frames: random data, write order and stall pattern.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 6; k++) begin
        int a;
        a = (k < FL) ? k : int'($urandom_range(FL - 1, 0));
        do_write(a, dense_word_t'($urandom), 1'b1);
      end
      mask = ($urandom & $urandom) & 32'h0000_FFFF;
      do_commit();
      run_frame(mask, "random", 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
